gray_counter_param: RTL and testbench

//  Parametrised up/down binary counter with a registered, glitch-free Gray-code output.

---
 rtl/gray_counter_param_if.sv | 28 ++
 rtl/gray_counter_param.sv | 72 +++++++
 tb/tb_gray_counter_param.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/gray_counter_param_if.sv
// Handshake bundle for gray_counter_param: control inputs plus registered binary/Gray/tc outputs.
// load_is_gray exists only when GRAY_CNT_LOAD_GRAY_EN is defined.
interface gray_counter_param_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
`ifdef GRAY_CNT_LOAD_GRAY_EN
  logic             load_is_gray;
`endif
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] gray_out;
  logic             tc;

`ifdef GRAY_CNT_LOAD_GRAY_EN
  modport master (output enable, up_dn, load, load_val, load_is_gray,
                  input  bin_out, gray_out, tc);
  modport slave  (input  enable, up_dn, load, load_val, load_is_gray,
                  output bin_out, gray_out, tc);
`else
  modport master (output enable, up_dn, load, load_val,
                  input  bin_out, gray_out, tc);
  modport slave  (input  enable, up_dn, load, load_val,
                  output bin_out, gray_out, tc);
`endif
endinterface

// File: rtl/gray_counter_param.sv
// Up/down binary counter with a flop-driven Gray output and terminal-count pulse; wraps or saturates.
// Optional macro GRAY_CNT_LOAD_GRAY_EN adds a Gray-coded load path (bus.load_is_gray).
module gray_counter_param #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_counter_param_if.slave  bus
);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] load_bin;
  logic             at_term;

`ifdef GRAY_CNT_LOAD_GRAY_EN
  assign load_bin = bus.load_is_gray ? gray2bin(bus.load_val) : bus.load_val;
`else
  assign load_bin = bus.load_val;
`endif

  assign at_term = bus.up_dn ? (bin_q == '1) : (bin_q == '0);

  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (bus.load) begin
      bin_d = load_bin;
    end else if (bus.enable) begin
      tc_d = at_term;
      // Saturation only suppresses the step at the terminal value; tc still fires.
      if (!(SATURATE && at_term)) begin
        bin_d = bus.up_dn ? bin_q + 1'b1 : bin_q - 1'b1;
      end
    end
    // Gray is encoded from the next binary value so both outputs update together.
    gray_d = bin2gray(bin_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= RESET_VAL;
      gray_q <= bin2gray(RESET_VAL);
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign bus.bin_out  = bin_q;
  assign bus.gray_out = gray_q;
  assign bus.tc       = tc_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Randomized plus directed bench: three configurations (wrap, saturate, RESET_VAL=0x10) against an arithmetic model.
module tb_gray_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, ld, ldg;
  logic [7:0] ldv;

  int total = 0;
  int bad   = 0;

  gray_counter_param_if #(.WIDTH(8)) if0 ();
  gray_counter_param_if #(.WIDTH(8)) if1 ();
  gray_counter_param_if #(.WIDTH(8)) if2 ();

  assign if0.enable = en;  assign if0.up_dn = up;  assign if0.load = ld;  assign if0.load_val = ldv;
  assign if1.enable = en;  assign if1.up_dn = up;  assign if1.load = ld;  assign if1.load_val = ldv;
  assign if2.enable = en;  assign if2.up_dn = up;  assign if2.load = ld;  assign if2.load_val = ldv;
`ifdef GRAY_CNT_LOAD_GRAY_EN
  assign if0.load_is_gray = ldg;
  assign if1.load_is_gray = ldg;
  assign if2.load_is_gray = ldg;
`endif

  gray_counter_param #(.WIDTH(8), .RESET_VAL(8'h00), .SATURATE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  gray_counter_param #(.WIDTH(8), .RESET_VAL(8'h00), .SATURATE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  gray_counter_param #(.WIDTH(8), .RESET_VAL(8'h10), .SATURATE(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic [7:0] db [3];
  logic [7:0] dg [3];
  logic       dt [3];
  assign db[0] = if0.bin_out;  assign dg[0] = if0.gray_out;  assign dt[0] = if0.tc;
  assign db[1] = if1.bin_out;  assign dg[1] = if1.gray_out;  assign dt[1] = if1.tc;
  assign db[2] = if2.bin_out;  assign dg[2] = if2.gray_out;  assign dt[2] = if2.tc;

  localparam bit         SATC [3] = '{1'b0, 1'b1, 1'b0};
  localparam logic [7:0] RVC  [3] = '{8'h00, 8'h00, 8'h10};

  typedef struct packed {
    logic [7:0] b;
    logic       tc;
    logic       step;
  } mst_t;

  mst_t m [3];
  logic vld = 1'b0;
  logic [7:0] gprev [3];

  // Gray-to-binary as a prefix XOR of right shifts.
  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] r;
    r = '0;
    for (int s = 0; s < 8; s++) r = r ^ (g >> s);
    return r;
  endfunction

  function automatic logic [7:0] b2g(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic mst_t mnext(input mst_t s, input bit sat, input logic [7:0] rv,
                                 input logic r, input logic l, input logic lg,
                                 input logic [7:0] lv, input logic e, input logic u);
    mst_t n;
    int   t;
    n.b = s.b;  n.tc = 1'b0;  n.step = 1'b0;
    if (r) begin
      n.b = rv;
    end else if (l) begin
      n.b = lg ? g2b(lv) : lv;
    end else if (e) begin
      t = u ? int'(s.b) + 1 : int'(s.b) - 1;
      if (t > 255 || t < 0) begin
        n.tc = 1'b1;
        n.b  = sat ? s.b : 8'((t + 256) % 256);
      end else begin
        n.b = 8'(t);
      end
      n.step = (n.b != s.b);
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) vld <= 1'b1;
    for (int i = 0; i < 3; i++)
      m[i] <= mnext(m[i], SATC[i], RVC[i], rst, ld, ldg, ldv, en, up);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (vld) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("bin[%0d]", i), int'(db[i]), int'(m[i].b));
        chk($sformatf("gray[%0d]", i), int'(dg[i]), int'(b2g(m[i].b)));
        chk($sformatf("tc[%0d]", i), int'(dt[i]), int'(m[i].tc));
        if (m[i].step) chk($sformatf("onebit[%0d]", i), $countones(dg[i] ^ gprev[i]), 1);
        gprev[i] <= dg[i];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; ldg = 1'b0; ldv = 8'h00;
    repeat (2) tick();
    chk("rst_bin0", int'(db[0]), 8'h00);
    chk("rst_tc0", int'(dt[0]), 0);
    chk("rst_bin2", int'(db[2]), 8'h10);
    chk("rst_gray2", int'(dg[2]), 8'h18);

    // Free-running up count through the wrap.
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 3) chk("up_gray3", int'(dg[0]), 8'h02);
      if (i == 255) begin
        chk("up_gray255", int'(dg[0]), 8'h80);
        chk("up_tc255", int'(dt[0]), 0);
      end
      if (i == 256) begin
        chk("wrap_bin", int'(db[0]), 8'h00);
        chk("wrap_tc", int'(dt[0]), 1);
      end
      if (i == 257) chk("wrap_tc_next", int'(dt[0]), 0);
    end

    // Load 5 then count down past zero.
    en = 1'b0; ld = 1'b1; ldv = 8'h05;
    tick();
    chk("load5", int'(db[0]), 8'h05);
    ld = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) begin
        chk("down_bin255", int'(db[0]), 8'hFF);
        chk("down_tc", int'(dt[0]), 1);
      end
      if (i == 7) chk("down_bin254", int'(db[0]), 8'hFE);
    end

    // Saturating instance at the top.
    en = 1'b0; ld = 1'b1; ldv = 8'hFD;
    tick();
    ld = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 2) chk("sat_tc_reach", int'(dt[1]), 0);
      if (i == 5) begin
        chk("sat_bin", int'(db[1]), 8'hFF);
        chk("sat_gray", int'(dg[1]), 8'h80);
        chk("sat_tc", int'(dt[1]), 1);
      end
    end

    // Simultaneous events.
    ld = 1'b1; ldv = 8'h40; en = 1'b1;
    tick();
    chk("ld_over_en", int'(db[0]), 8'h40);
    rst = 1'b1; ldv = 8'h33;
    tick();
    chk("rst_over_ld_bin", int'(db[0]), 8'h00);
    chk("rst_over_ld_gray", int'(dg[0]), 8'h00);

    // Reset mid-count on the RESET_VAL=0x10 instance.
    rst = 1'b0; ld = 1'b1; ldv = 8'h7F; en = 1'b0;
    tick();
    ld = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_bin", int'(db[2]), 8'h10);
    chk("midrst_gray", int'(dg[2]), 8'h18);
    chk("midrst_tc", int'(dt[2]), 0);
    rst = 1'b0;
    tick();
    chk("resume_bin", int'(db[2]), 8'h11);

`ifdef GRAY_CNT_LOAD_GRAY_EN
    en = 1'b0; ld = 1'b1; ldg = 1'b1; ldv = 8'hC0;
    tick();
    chk("gload_bin", int'(db[0]), 8'h80);
    chk("gload_gray", int'(dg[0]), 8'hC0);
    ld = 1'b0; ldg = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk("gload_step_bin", int'(db[0]), 8'h81);
    chk("gload_step_gray", int'(dg[0]), 8'hC1);
`endif

    // Randomized traffic, biased toward the range ends.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      ld  = ($urandom_range(0, 99) < 8);
      en  = ($urandom_range(0, 99) < 75);
      up  = ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0;
      case ($urandom_range(0, 3))
        0:       ldv = 8'h00;
        1:       ldv = 8'hFF;
        default: ldv = 8'($urandom);
      endcase
`ifdef GRAY_CNT_LOAD_GRAY_EN
      ldg = $urandom_range(0, 1) == 1;
`endif
      tick();
    end

    rst = 1'b0; ld = 1'b0; en = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
